// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ hash clients.
// One queued request per client; a client holding a stored midstate keeps the core.
module hash_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int KEY_LEN = 256,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_start,
    input  logic [NUM_REQ*1024-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]      req_message_length,
    input  logic [NUM_REQ-1:0]      req_store_intermediate,
    input  logic [NUM_REQ-1:0]      req_continue_interm,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [KEY_LEN-1:0]      req_data_out,
    output logic [NUM_REQ-1:0]      req_overflow,
    output logic                    busy,
    output logic                    hash_start,
    output logic [1023:0]           hash_data_in,
    output logic                    message_length,
    output logic                    store_intermediate,
    output logic                    continue_intermediate,
    input  logic                    hash_done,
    input  logic [KEY_LEN-1:0]      hash_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [1023:0]        slot_data_q [NUM_REQ];
    logic [1023:0]        slot_data_d [NUM_REQ];
    logic [NUM_REQ-1:0]   slot_len_q, slot_len_d;
    logic [NUM_REQ-1:0]   slot_store_q, slot_store_d;
    logic [NUM_REQ-1:0]   slot_cont_q, slot_cont_d;
    logic                 lock_q, lock_d;
    logic [IDX_W-1:0]     lock_id_q, lock_id_d;
    logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [1023:0]        data_q, data_d;
    logic                 len_q, len_d;
    logic                 store_q, store_d;
    logic                 cont_q, cont_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [KEY_LEN-1:0]   dout_q, dout_d;
    logic [NUM_REQ-1:0]   ovf_q, ovf_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   clr;
    logic [NUM_REQ-1:0]   accept;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;

    always_comb begin
        state_d      = state_q;
        slot_data_d  = slot_data_q;
        slot_len_d   = slot_len_q;
        slot_store_d = slot_store_q;
        slot_cont_d  = slot_cont_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        last_gnt_d   = last_gnt_q;
        gnt_d        = gnt_q;
        data_d       = data_q;
        len_d        = len_q;
        store_d      = store_q;
        cont_d       = cont_q;
        done_d       = '0;
        dout_d       = '0;
        clr          = '0;
        sel_found    = 1'b0;
        sel_idx      = '0;

        eligible = lock_q ? (pending_q & (NUM_REQ'(1) << lock_id_q)) : pending_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!sel_found && eligible[(int'(last_gnt_q) + k) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(last_gnt_q) + k) % NUM_REQ);
            end
        end

        unique case (state_q)
            IDLE: begin
                // Hold off one cycle while the done pulse is on the bus
                if (sel_found && done_q == '0) begin
                    gnt_d        = sel_idx;
                    data_d       = slot_data_q[sel_idx];
                    len_d        = slot_len_q[sel_idx];
                    store_d      = slot_store_q[sel_idx];
                    cont_d       = slot_cont_q[sel_idx];
                    clr[sel_idx] = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                last_gnt_d = gnt_q;
                state_d    = WAIT;
            end
            WAIT: begin
                if (hash_done) begin
                    done_d[gnt_q] = 1'b1;
                    dout_d        = hash_data_out;
                    lock_d        = store_q;
                    lock_id_d     = gnt_q;
                    data_d        = '0;
                    len_d         = 1'b0;
                    store_d       = 1'b0;
                    cont_d        = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start from the client being granted this cycle is re-latched
        accept    = req_start & (~pending_q | clr);
        ovf_d     = ovf_q | (req_start & pending_q & ~clr);
        pending_d = (pending_q & ~clr) | accept;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                slot_data_d[i]  = req_data_in[i*1024 +: 1024];
                slot_len_d[i]   = req_message_length[i];
                slot_store_d[i] = req_store_intermediate[i];
                slot_cont_d[i]  = req_continue_interm[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot_data_q[i] <= '0;
            slot_len_q   <= '0;
            slot_store_q <= '0;
            slot_cont_q  <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            last_gnt_q   <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            data_q       <= '0;
            len_q        <= 1'b0;
            store_q      <= 1'b0;
            cont_q       <= 1'b0;
            done_q       <= '0;
            dout_q       <= '0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            slot_data_q  <= slot_data_d;
            slot_len_q   <= slot_len_d;
            slot_store_q <= slot_store_d;
            slot_cont_q  <= slot_cont_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_gnt_q   <= last_gnt_d;
            gnt_q        <= gnt_d;
            data_q       <= data_d;
            len_q        <= len_d;
            store_q      <= store_d;
            cont_q       <= cont_d;
            done_q       <= done_d;
            dout_q       <= dout_d;
            ovf_q        <= ovf_d;
        end
    end

    assign req_done              = done_q;
    assign req_data_out          = dout_q;
    assign req_overflow          = ovf_q;
    assign busy                  = (state_q != IDLE);
    assign hash_start            = (state_q == ISSUE);
    assign hash_data_in          = data_q;
    assign message_length        = len_q;
    assign store_intermediate    = store_q;
    assign continue_intermediate = cont_q;

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter: latency, round-robin order, lock,
// overflow and reset behaviour against hand-computed expectations.
module tb_hash_arbiter;

    localparam int N = 3;
    localparam int K = 256;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_start;
    logic [N*1024-1:0] req_data_in;
    logic [N-1:0]    req_message_length;
    logic [N-1:0]    req_store_intermediate;
    logic [N-1:0]    req_continue_interm;
    logic [N-1:0]    req_done;
    logic [K-1:0]    req_data_out;
    logic [N-1:0]    req_overflow;
    logic            busy;
    logic            hash_start;
    logic [1023:0]   hash_data_in;
    logic            message_length;
    logic            store_intermediate;
    logic            continue_intermediate;
    logic            hash_done;
    logic [K-1:0]    hash_data_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1023:0] exp_msg [N];
    logic          exp_len [N];
    logic          exp_st  [N];
    logic          exp_ct  [N];

    hash_arbiter #(.NUM_REQ(N), .KEY_LEN(K)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .req_start              (req_start),
        .req_data_in            (req_data_in),
        .req_message_length     (req_message_length),
        .req_store_intermediate (req_store_intermediate),
        .req_continue_interm    (req_continue_interm),
        .req_done               (req_done),
        .req_data_out           (req_data_out),
        .req_overflow           (req_overflow),
        .busy                   (busy),
        .hash_start             (hash_start),
        .hash_data_in           (hash_data_in),
        .message_length         (message_length),
        .store_intermediate     (store_intermediate),
        .continue_intermediate  (continue_intermediate),
        .hash_done              (hash_done),
        .hash_data_out          (hash_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [K-1:0] got,
                       input logic [K-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] mk(input logic [31:0] v);
        return {32{v}};
    endfunction

    function automatic logic [K-1:0] dig(input logic [31:0] v);
        return {8{32'hD1570000 | v}};
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        req_start = '0;
        hash_done = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // one-cycle start pulse for client c
    task automatic start(input int c, input logic [31:0] v,
                         input bit st, input bit ct);
        req_data_in[c*1024 +: 1024] = mk(v);
        req_message_length[c]       = (c == 2);
        req_store_intermediate[c]   = st;
        req_continue_interm[c]      = ct;
        req_start[c]                = 1'b1;
        exp_msg[c] = mk(v);
        exp_len[c] = (c == 2);
        exp_st[c]  = st;
        exp_ct[c]  = ct;
        tick();
        req_start = '0;
    endtask

    // wait for hash_start and check that client c's request is on the bus
    task automatic wait_issue(input int c);
        for (int n = 0; n < 100 && !hash_start; n++) tick();
        chk("issue_seen", K'(hash_start), K'(1));
        chk($sformatf("issue_msg%0d", c), K'(hash_data_in == exp_msg[c]), K'(1));
        chk($sformatf("issue_flags%0d", c),
            K'({message_length, store_intermediate, continue_intermediate}),
            K'({exp_len[c], exp_st[c], exp_ct[c]}));
        tick();
        chk("start_one_cycle", K'(hash_start), K'(0));
    endtask

    // core replies after lat cycles; done pulse checked one cycle later
    task automatic finish(input int c, input int lat, input logic [31:0] v);
        repeat (lat) tick();
        hash_done     = 1'b1;
        hash_data_out = dig(v);
        tick();
        hash_done     = 1'b0;
        hash_data_out = '0;
        chk($sformatf("done%0d", c), K'(req_done), K'(1 << c));
        chk($sformatf("dout%0d", c), req_data_out, dig(v));
        tick();
        chk("done_pulse_end", K'(req_done), K'(0));
    endtask

    int hs_cnt;

    initial begin
        req_data_in            = '0;
        req_message_length     = '0;
        req_store_intermediate = '0;
        req_continue_interm    = '0;
        hash_data_out          = '0;
        do_reset();
        chk("rst_busy", K'(busy), K'(0));
        chk("rst_done", K'(req_done), K'(0));
        chk("rst_ovf", K'(req_overflow), K'(0));
        chk("rst_hs", K'(hash_start), K'(0));
        chk("rst_din0", K'(hash_data_in == '0), K'(1));

        // 1: single request latency, stray done in ISSUE ignored
        start(0, 32'hAAAA0001, 1'b0, 1'b0);
        chk("t1_hs_t1", K'(hash_start), K'(0));
        tick();
        chk("t1_hs_t2", K'(hash_start), K'(1));
        hash_done = 1'b1;
        wait_issue(0);
        hash_done = 1'b0;
        tick();
        chk("t1_issue_done_ign", K'(req_done), K'(0));
        chk("t1_busy", K'(busy), K'(1));
        finish(0, 3, 32'h1);
        chk("t1_idle_din0", K'(hash_data_in == '0), K'(1));
        chk("t1_idle_busy", K'(busy), K'(0));

        // 2: three simultaneous starts, order 0,1,2, earliest restart d+3
        do_reset();
        req_data_in[0 +: 1024]    = mk(32'h20);
        req_data_in[1024 +: 1024] = mk(32'h21);
        req_data_in[2048 +: 1024] = mk(32'h22);
        req_message_length     = 3'b100;
        req_store_intermediate = '0;
        req_continue_interm    = '0;
        for (int c = 0; c < N; c++) begin
            exp_msg[c] = mk(32'h20 + c);
            exp_len[c] = (c == 2);
            exp_st[c]  = 1'b0;
            exp_ct[c]  = 1'b0;
        end
        req_start = 3'b111;
        tick();
        req_start = '0;
        wait_issue(0);
        repeat (10) tick();
        hash_done = 1'b1;
        hash_data_out = dig(32'h20);
        tick();
        hash_done = 1'b0;
        chk("t2_done0", K'(req_done), K'(3'b001));
        tick();
        chk("t2_hs_d2", K'(hash_start), K'(0));
        tick();
        chk("t2_hs_d3", K'(hash_start), K'(1));
        wait_issue(1);
        finish(1, 10, 32'h21);
        wait_issue(2);
        finish(2, 10, 32'h22);
        chk("t2_ovf", K'(req_overflow), K'(0));

        // 3: lock held by client 1 across store/continue
        do_reset();
        start(1, 32'h31, 1'b1, 1'b0);
        wait_issue(1);
        finish(1, 4, 32'h31);
        start(0, 32'h30, 1'b0, 1'b0);
        start(2, 32'h32, 1'b0, 1'b0);
        hs_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (hash_start) hs_cnt++;
            tick();
        end
        chk("t3_lock_hold", K'(hs_cnt), K'(0));
        chk("t3_lock_idle", K'(busy), K'(0));
        start(1, 32'h33, 1'b0, 1'b1);
        wait_issue(1);
        finish(1, 4, 32'h33);
        // round robin resumes after client 1
        wait_issue(2);
        finish(2, 2, 32'h32);
        wait_issue(0);
        finish(0, 2, 32'h30);

        // 4: overflow while pending, accept during own WAIT
        do_reset();
        start(0, 32'h40, 1'b0, 1'b0);
        wait_issue(0);
        start(2, 32'h41, 1'b0, 1'b0);
        start(2, 32'h42, 1'b0, 1'b0);
        start(2, 32'h43, 1'b0, 1'b0);
        chk("t4_ovf", K'(req_overflow), K'(3'b100));
        finish(0, 1, 32'h40);
        exp_msg[2] = mk(32'h41);
        wait_issue(2);
        start(2, 32'h44, 1'b0, 1'b0);
        chk("t4_ovf_wait", K'(req_overflow), K'(3'b100));
        finish(2, 1, 32'h41);
        wait_issue(2);
        finish(2, 1, 32'h44);

        // 5: reset during WAIT drops everything
        do_reset();
        start(0, 32'h50, 1'b0, 1'b0);
        start(1, 32'h51, 1'b0, 1'b0);
        wait_issue(0);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t5_busy", K'(busy), K'(0));
        chk("t5_done", K'(req_done), K'(0));
        chk("t5_din", K'(hash_data_in == '0), K'(1));
        tick();
        reset_n = 1'b1;
        hash_done = 1'b1;
        hash_data_out = dig(32'h50);
        tick();
        hash_done = 1'b0;
        chk("t5_stray", K'(req_done), K'(0));
        hs_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (hash_start || req_done != '0) hs_cnt++;
            tick();
        end
        chk("t5_no_pending", K'(hs_cnt), K'(0));

        // 6: all clients kept pending -> strict rotation
        do_reset();
        req_data_in[0 +: 1024]    = mk(32'h60);
        req_data_in[1024 +: 1024] = mk(32'h61);
        req_data_in[2048 +: 1024] = mk(32'h62);
        req_message_length     = 3'b100;
        req_store_intermediate = '0;
        req_continue_interm    = '0;
        for (int c = 0; c < N; c++) begin
            exp_msg[c] = mk(32'h60 + c);
            exp_len[c] = (c == 2);
            exp_st[c]  = 1'b0;
            exp_ct[c]  = 1'b0;
        end
        req_start = 3'b111;
        tick();
        req_start = '0;
        for (int r = 0; r < 6; r++) begin
            wait_issue(r % N);
            finish(r % N, 2, 32'h600 + r);
            start(r % N, 32'h60 + (r % N), 1'b0, 1'b0);
        end
        chk("t6_ovf", K'(req_overflow), K'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
